// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Bus-slave 4-digit multiplexed seven-segment scan controller
//               with shadow/display registers for tear-free frame updates.
//               Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 1024,
  parameter int SEL_BIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_select,
  input  logic        bus_w,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data,
  output logic [31:0] rdata,
  output logic [7:0]  segment_data,
  output logic [3:0]  AN
);

  localparam logic [15:0] c_CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [8:0]  c_CTRL_RST = 9'h0F0;
  localparam logic [1:0]  c_DIG_LAST = 2'd3;

  // Registered state
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  dig_q,      dig_d;
  logic [15:0] shadow_q,   shadow_d;
  logic [15:0] disp_q,     disp_d;
  logic [8:0]  ctrl_q,     ctrl_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [3:0]  an_q,       an_d;
  logic [7:0]  seg_q,      seg_d;

  // Combinational helpers
  logic        w_wr;
  logic        w_wr_data;
  logic        w_wr_ctrl;
  logic        w_wrap;
  logic        w_boundary;
  logic [3:0]  w_dp_mask;
  logic [3:0]  w_en_mask;
  logic [3:0]  w_lz_blank;
  logic [3:0]  w_nib;
  logic        w_dig_on;
  logic        w_unused;

  // Segment patterns g..a, active-low
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // Digit k goes dark when it and every digit to its left hold zero
  always_comb begin
    w_lz_blank    = 4'b0000;
    w_lz_blank[3] = (disp_q[15:12] == 4'h0);
    w_lz_blank[2] = (disp_q[15:8]  == 8'h00);
    w_lz_blank[1] = (disp_q[15:4]  == 12'h000);
  end
`else
  assign w_lz_blank = 4'b0000;
`endif

  // Bus decode and scan timing
  always_comb begin
    w_wr       = bus_w & bus_select[SEL_BIT];
    w_wr_data  = w_wr & ~bus_addr[2];
    w_wr_ctrl  = w_wr &  bus_addr[2];
    w_wrap     = (scan_cnt_q == c_CNT_LAST);
    w_boundary = w_wrap && (dig_q == c_DIG_LAST);
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    dig_d      = dig_q;
    if (w_wrap) begin
      scan_cnt_d = 16'd0;
      dig_d      = dig_q + 2'd1;
    end
  end

  // Register file and frame transfer
  always_comb begin
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    disp_d   = disp_q;
    if (w_wr_data) begin
      shadow_d = bus_data[15:0];
    end
    if (w_wr_ctrl) begin
      ctrl_d = bus_data[8:0];
    end
    // A data write on the boundary cycle bypasses the shadow so it is not lost for a frame
    if (w_boundary && !ctrl_q[8]) begin
      disp_d = w_wr_data ? bus_data[15:0] : shadow_q;
    end
  end

  always_comb begin
    rdata_d = bus_addr[2] ? {23'd0, ctrl_q} : {16'd0, shadow_q};
  end

  // Output stage
  always_comb begin
    w_dp_mask = ctrl_q[3:0];
    w_en_mask = ctrl_q[7:4];
    w_nib     = disp_q[{dig_q, 2'b00} +: 4];
    w_dig_on  = w_en_mask[dig_q] & ~w_lz_blank[dig_q];
    an_d      = 4'b1111;
    seg_d     = 8'hFF;
    if (w_dig_on) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {~w_dp_mask[dig_q], hex7(w_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= 16'd0;
      dig_q      <= 2'd0;
      shadow_q   <= 16'd0;
      disp_q     <= 16'd0;
      ctrl_q     <= c_CTRL_RST;
      rdata_q    <= 32'd0;
      an_q       <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign rdata        = rdata_q;
  assign AN           = an_q;
  assign segment_data = seg_q;

  // Only a few bus bits are decoded
  assign w_unused = ^{bus_select, bus_addr, bus_data};

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl
//               (SCAN_DIV=4, SEL_BIT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int SEL_BIT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_select;
  logic        bus_w;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [31:0] rdata;
  logic [7:0]  segment_data;
  logic [3:0]  AN;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .SEL_BIT (SEL_BIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_select  (bus_select),
    .bus_w       (bus_w),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .rdata       (rdata),
    .segment_data(segment_data),
    .AN          (AN)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_select = 32'h0000_0002;
    bus_w      = 1'b1;
    bus_addr   = addr;
    bus_data   = data;
    tick();
    bus_w      = 1'b0;
    bus_select = 32'h0;
  endtask

  // Advance to just after the next frame-boundary edge
  task automatic align();
    tick();
    while (cyc % 16 != 0) tick();
  endtask

  // One full frame starting right after a boundary edge; segs = {d3,d2,d1,d0}
  task automatic check_frame(input string tag, input logic [31:0] segs, input logic [3:0] en);
    logic [3:0] e_an;
    logic [7:0] e_seg;
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        e_an  = en[d] ? ~(4'b0001 << d) : 4'b1111;
        e_seg = en[d] ? segs[d*8 +: 8] : 8'hFF;
        check($sformatf("%s_an_d%0d", tag, d), {28'd0, AN}, {28'd0, e_an});
        check($sformatf("%s_seg_d%0d", tag, d), {24'd0, segment_data}, {24'd0, e_seg});
      end
    end
  endtask

  // Expected AN for the digit scanned before the most recent edge
  function automatic logic [3:0] an_now();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (((cyc - 1) / 4) % 4));
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    bus_select = 32'h0;
    bus_w      = 1'b0;
    bus_addr   = 32'h0;
    bus_data   = 32'h0;
    tick();
    tick();
    check("rst_an",    {28'd0, AN},           32'h0000_000F);
    check("rst_seg",   {24'd0, segment_data}, 32'h0000_00FF);
    check("rst_rdata", rdata,                 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Idle scan after reset
    check_frame("idle", 32'hC0C0_C0C0, 4'hF);

    // Mid-frame data write: display must not change before the boundary
    repeat (5) tick();
    wr(32'h0, 32'hFFFF_1234);
    bus_addr = 32'h0;
    tick();
    check("rd_shadow", rdata, 32'h0000_1234);
    check("hold_an",   {28'd0, AN}, {28'd0, an_now()});
    check("hold_seg",  {24'd0, segment_data}, 32'h0000_00C0);

    // Ignored writes: wrong select bit, then strobe low
    bus_select = 32'h0000_0001; bus_w = 1'b1; bus_data = 32'h0000_DEAD;
    tick();
    bus_select = 32'h0000_0002; bus_w = 1'b0; bus_data = 32'h0000_BEEF;
    tick();
    bus_select = 32'h0;
    tick();
    check("rd_ignored", rdata, 32'h0000_1234);

    align();
    check_frame("f1234", 32'hF9A4_B099, 4'hF);
    bus_addr = 32'h4;
    tick();
    check("rd_ctrl_rst", rdata, 32'h0000_00F0);

    // Freeze: shadow updates, display holds
    wr(32'h4, 32'h0000_01F0);
    wr(32'h0, 32'h0000_ABCD);
    bus_addr = 32'h0;
    tick();
    check("rd_abcd", rdata, 32'h0000_ABCD);
    bus_addr = 32'h4;
    tick();
    check("rd_freeze", rdata, 32'h0000_01F0);
    align();
    check_frame("frz1", 32'hF9A4_B099, 4'hF);
    check_frame("frz2", 32'hF9A4_B099, 4'hF);

    // Unfreeze mid-frame: transfer waits for the boundary
    tick();
    wr(32'h4, 32'h0000_00F0);
    tick();
    check("unfrz_an",  {28'd0, AN}, {28'd0, an_now()});
    check("unfrz_seg", {24'd0, segment_data}, 32'h0000_0099);
    align();
    check_frame("fabcd", 32'h8883_C6A1, 4'hF);

    // Enable digits 0,1 only; dp on digits 0 and 2
    tick();
    wr(32'h4, 32'h0000_0035);
    align();
    check_frame("c035", 32'h8883_C621, 4'b0011);

    // Data write landing exactly on the boundary edge wins over the shadow
    wr(32'h4, 32'h0000_00F0);
    wr(32'h0, 32'h0000_1111);
    while (cyc % 16 != 15) tick();
    wr(32'h0, 32'h0000_5678);
    check_frame("bnd", 32'h9282_F880, 4'hF);

    // Reset mid-frame with a coincident ctrl write
    repeat (3) tick();
    rst = 1'b1; bus_select = 32'h0000_0002; bus_w = 1'b1;
    bus_addr = 32'h4; bus_data = 32'h0000_01FF;
    tick();
    check("mrst_an",    {28'd0, AN}, 32'h0000_000F);
    check("mrst_seg",   {24'd0, segment_data}, 32'h0000_00FF);
    check("mrst_rdata", rdata, 32'h0);
    rst = 1'b0; bus_w = 1'b0; bus_select = 32'h0;
    cyc = 0;
    tick();
    check("mrst_ctrl", rdata, 32'h0000_00F0);
    check("mrst_an1",  {28'd0, AN}, 32'h0000_000E);
    check("mrst_seg1", {24'd0, segment_data}, 32'h0000_00C0);

    // Leading zeros
    wr(32'h0, 32'h0000_0007);
    align();
`ifdef SEG_LZ_BLANK_EN
    check_frame("lz7", 32'hFFFF_FFF8, 4'b0001);
`else
    check_frame("lz7", 32'hC0C0_C0F8, 4'hF);
`endif
    wr(32'h0, 32'h0000_0000);
    align();
`ifdef SEG_LZ_BLANK_EN
    check_frame("lz0", 32'hFFFF_FFC0, 4'b0001);
`else
    check_frame("lz0", 32'hC0C0_C0C0, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
